// File: rtl/stream_mux_rr_pkg.sv
// Shared constants and helpers for the N-channel packet-aware stream mux.
package stream_mux_rr_pkg;

  localparam int MUX_MODE_RR    = 0;
  localparam int MUX_MODE_FIXED = 1;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/stream_mux_rr_pick.sv
// Combinational rotating priority pick: first request at or after base, wrapping mod N.
// With fixed=1 the scan starts at index 0, giving lowest-index-wins priority.
module rr_pick
  import stream_mux_rr_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] base,
  input  logic          fixed,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  localparam logic [IW:0] NV = (IW+1)'(N);

  logic [IW-1:0]  eff_base;
  logic [IW:0]    base_x;
  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [IW:0]    s;

  assign eff_base = fixed ? '0 : base;
  assign base_x   = {1'b0, eff_base};
  // Doubling the request vector turns the wrap-around scan into a plain window select.
  assign dbl      = {req, req};
  assign rot      = dbl[base_x +: N];

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    s   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        any = 1'b1;
        s   = base_x + (IW+1)'(k);
        if (s >= NV) s = s - NV;
        idx = s[IW-1:0];
      end
    end
    if (any) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel registered stream mux with valid/ready handshake; round-robin or
// fixed-priority arbitration, with the grant held for a whole packet.
module stream_mux_rr
  import stream_mux_rr_pkg::*;
#(
  parameter  int WIDTH = 4,
  parameter  int N     = 4,
  parameter  int MODE  = MUX_MODE_RR,
  localparam int IW    = clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  input  logic [N-1:0]         in_last,
  output logic [N-1:0]         in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  output logic                 out_last,
  output logic [IW-1:0]        out_sel,
  input  logic                 out_ready
);

  logic          load;
  logic          lock;
  logic [IW-1:0] lock_ch;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] next_ptr;
  logic [N-1:0]  lock_mask;
  logic [N-1:0]  req;
  logic [N-1:0]  gnt;
  logic [IW-1:0] idx;
  logic          any;
  logic [WIDTH-1:0] sel_data;
  logic          sel_last;

  assign load = !out_valid || out_ready;

  always_comb begin
    lock_mask          = '0;
    lock_mask[lock_ch] = 1'b1;
  end

  // While a packet is open only its channel may request; a bubble there yields no grant.
  assign req = lock ? (in_valid & lock_mask) : in_valid;

  rr_pick #(.N(N)) u_pick (
    .req   (req),
    .base  (rr_ptr),
    .fixed (MODE == MUX_MODE_FIXED),
    .gnt   (gnt),
    .idx   (idx),
    .any   (any)
  );

  assign in_ready = (load && rst_n) ? gnt : '0;
  assign next_ptr = (idx == IW'(N - 1)) ? '0 : idx + IW'(1);

  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (gnt[i]) begin
        sel_data = in_data[i*WIDTH +: WIDTH];
        sel_last = in_last[i];
      end
    end
  end

  // Output register stage: one cycle from input transfer to out_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_sel   <= '0;
      rr_ptr    <= '0;
      lock      <= 1'b0;
      lock_ch   <= '0;
    end else if (load) begin
      if (any) begin
        out_valid <= 1'b1;
        out_data  <= sel_data;
        out_last  <= sel_last;
        out_sel   <= idx;
        if (sel_last) begin
          lock <= 1'b0;
          if (MODE == MUX_MODE_RR) rr_ptr <= next_ptr;
        end else begin
          lock    <= 1'b1;
          lock_ch <= idx;
        end
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
